adv_counter_core: RTL and testbench

Parametrised successor to the fixed three-digit decimal counter datapath. It holds DIGITS independent digit registers of arbitrary radix. Each digit steps from per-digit button levels, with an automatic hold-to-repeat function, optional ripple carry/borrow, a capturable per-digit ceiling, and top-level overflow/underflow pulses. It sits between the input synchroniser (already debounced, active-high levels) and the display decode/shift stage, replacing the separate counter-array and mode-select logic.

---
 rtl/adv_counter_if.sv | 26 ++
 rtl/adv_counter_core.sv | 176 +++++++++++++++++
 tb/tb_adv_counter_core.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adv_counter_if.sv
// Bundles the digit-counter control inputs and the count/limit/pulse outputs
// so the counter core and its driver share one port list.
interface adv_counter_if #(
  parameter int DIGITS = 3
);
  logic [DIGITS-1:0]   step;
  logic                down;
  logic                carry_en;
  logic                limit_en;
  logic                limit_capture;
  logic                clear;
  logic [4*DIGITS-1:0] cnt_out;
  logic [4*DIGITS-1:0] limit_out;
  logic                overflow;
  logic                underflow;

  modport master (
    output step, down, carry_en, limit_en, limit_capture, clear,
    input  cnt_out, limit_out, overflow, underflow
  );

  modport slave (
    input  step, down, carry_en, limit_en, limit_capture, clear,
    output cnt_out, limit_out, overflow, underflow
  );
endinterface

// File: rtl/adv_counter_core.sv
// Multi-digit counter of arbitrary radix. One held button owns the counter
// at a time, steps it once on press and then auto-repeats. Carries and
// borrows ripple upward within the cycle. A captured per-digit ceiling can
// replace RADIX-1 as the wrap point.
module adv_counter_core #(
  parameter int DIGITS       = 3,
  parameter int RADIX        = 10,
  parameter int REPEAT_DELAY = 16380,
  parameter int REPEAT_RATE  = 4096
) (
  input logic         clk,
  input logic         rst_n,
  adv_counter_if.slave bus
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] TOP = 4'(RADIX - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DIGITS-1:0]      step_q, press;
  logic                   press_any, hold_bit, repeat_hit, ev;
  logic [IW-1:0]          press_idx, act_q, ev_idx;
  logic [TW-1:0]          timer_q;
  logic                   rep_q;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, lim_q;
  logic                   ovf_q, unf_q, ovf_d, unf_d;
  logic                   carry, hit;
  logic [3:0]             ceil_v;

  assign bus.cnt_out   = cnt_q;
  assign bus.limit_out = lim_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

  assign hold_bit   = bus.step[act_q];
  assign repeat_hit = rep_q ? (timer_q == TW'(REPEAT_RATE))
                            : (timer_q == TW'(REPEAT_DELAY));

  // New-press detection; the descending scan leaves the lowest index winning.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    press     = bus.step & ~step_q;
    press_any = 1'b0;
    press_idx = '0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      if (press[j]) begin
        press_any = 1'b1;
        press_idx = IW'(j);
      end
    end
  end

  // Hold FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Hold FSM next state: clear freezes the hold state.
  always_comb begin
    state_d = state_q;
    if (!bus.clear) begin
      case (state_q)
        S_IDLE: if (press_any) state_d = S_HOLD;
        S_HOLD: if (!hold_bit) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Hold FSM output: step event on a fresh press or a repeat timer hit.
  always_comb begin
    ev     = 1'b0;
    ev_idx = act_q;
    if (!bus.clear) begin
      case (state_q)
        S_IDLE: if (press_any) begin
          ev     = 1'b1;
          ev_idx = press_idx;
        end
        S_HOLD: ev = hold_bit & repeat_hit;
        default: ev = 1'b0;
      endcase
    end
  end

  // Active digit, repeat timer and first-repeat/steady-rate phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q   <= '0;
      timer_q <= '0;
      rep_q   <= 1'b0;
    end else if (bus.clear) begin
      timer_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (press_any) begin
        act_q   <= press_idx;
        timer_q <= TW'(1);
        rep_q   <= 1'b0;
      end
    end else if (!hold_bit) begin
      timer_q <= '0;
    end else if (repeat_hit) begin
      timer_q <= TW'(1);
      rep_q   <= 1'b1;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Digit stepping with combinational ripple carry/borrow from the event digit up.
  always_comb begin
    cnt_d  = cnt_q;
    carry  = 1'b0;
    hit    = 1'b0;
    ceil_v = TOP;
    for (int j = 0; j < DIGITS; j++) begin
      ceil_v = bus.limit_en ? lim_q[j] : TOP;
      hit    = (ev && (ev_idx == IW'(j))) || carry;
      carry  = 1'b0;
      if (hit) begin
        if (!bus.down) begin
          if (cnt_q[j] >= ceil_v) begin
            cnt_d[j] = 4'd0;
            carry    = bus.carry_en;
          end else begin
            cnt_d[j] = cnt_q[j] + 4'd1;
          end
        end else begin
          if (cnt_q[j] == 4'd0) begin
            cnt_d[j] = ceil_v;
            carry    = bus.carry_en;
          end else if (cnt_q[j] > ceil_v) begin
            cnt_d[j] = ceil_v;
          end else begin
            cnt_d[j] = cnt_q[j] - 4'd1;
          end
        end
      end
    end
    ovf_d = carry & ~bus.down;
    unf_d = carry & bus.down;
  end

  // Count, limit and pulse registers; capture always takes the pre-update count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= '0;
      cnt_q  <= '0;
      // NOTE: the limit bank is a handful of flops, so it is reset directly
      // to the full-range ceiling rather than left undefined like a RAM.
      lim_q  <= {DIGITS{TOP}};
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      step_q <= bus.step;
      if (bus.clear) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
      if (bus.limit_capture) lim_q <= cnt_q;
    end
  end

endmodule

// File: tb/tb_adv_counter_core.sv
// Randomised and directed bench for adv_counter_core. A cycle model built
// from the counting rules predicts each post-edge output set; a monitor
// compares it against the DUT on every falling edge.
module tb_adv_counter_core;
  localparam int DIGITS = 3;
  localparam int RADIX  = 10;
  localparam int RD     = 8;
  localparam int RR     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adv_counter_if #(.DIGITS(DIGITS)) bus ();

  adv_counter_core #(
    .DIGITS(DIGITS), .RADIX(RADIX), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [4*DIGITS-1:0] cnt;
    logic [4*DIGITS-1:0] lim;
    logic                ovf;
    logic                unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: digit values, limits, owner of the hold and its age.
  int                m_cnt[DIGITS];
  int                m_lim[DIGITS];
  bit                m_ovf, m_unf;
  int                m_held = -1;
  int                m_age  = 0;
  bit [DIGITS-1:0]   m_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One step of a digit and whatever it carries into, digit by digit upward.
  function automatic void model_apply(input int j, input bit dn, input bit cen, input bit len);
    int pos = j;
    bit go  = 1'b1;
    int ceil;
    while (go && pos < DIGITS) begin
      ceil = len ? m_lim[pos] : RADIX - 1;
      go   = 1'b0;
      if (!dn) begin
        if (m_cnt[pos] >= ceil) begin m_cnt[pos] = 0; go = cen; end
        else m_cnt[pos] = m_cnt[pos] + 1;
      end else begin
        if (m_cnt[pos] == 0) begin m_cnt[pos] = ceil; go = cen; end
        else if (m_cnt[pos] > ceil) m_cnt[pos] = ceil;
        else m_cnt[pos] = m_cnt[pos] - 1;
      end
      pos++;
    end
    if (go) begin
      if (dn) m_unf = 1'b1;
      else    m_ovf = 1'b1;
    end
  endfunction

  // Predict the state after the coming clock edge from the inputs now applied.
  function automatic void model_cycle();
    int pre[DIGITS];
    int ev = -1;
    pre   = m_cnt;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!rst_n) begin
      for (int j = 0; j < DIGITS; j++) begin m_cnt[j] = 0; m_lim[j] = RADIX - 1; end
      m_held = -1;
      m_age  = 0;
      m_prev = '0;
      return;
    end
    if (bus.clear) begin
      for (int j = 0; j < DIGITS; j++) m_cnt[j] = 0;
    end else begin
      if (m_held < 0) begin
        for (int j = 0; j < DIGITS; j++) begin
          if (bus.step[j] && !m_prev[j]) begin m_held = j; m_age = 0; ev = j; break; end
        end
      end else if (!bus.step[m_held]) begin
        m_held = -1;
      end else begin
        m_age++;
        if (m_age >= RD && ((m_age - RD) % RR) == 0) ev = m_held;
      end
      if (ev >= 0) model_apply(ev, bus.down, bus.carry_en, bus.limit_en);
    end
    if (bus.limit_capture) m_lim = pre;
    m_prev = bus.step;
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    for (int j = 0; j < DIGITS; j++) begin
      e.cnt[4*j +: 4] = 4'(m_cnt[j]);
      e.lim[4*j +: 4] = 4'(m_lim[j]);
    end
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  // Advance one clock: predict, let the edge happen, queue the prediction.
  task automatic tick();
    model_cycle();
    @(posedge clk);
    exp_q.push_back(model_pack());
    #1;
  endtask

  task automatic press(input int j);
    bus.step = DIGITS'(1 << j);
    tick();
    bus.step = '0;
    tick();
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // Monitor: compare every queued prediction on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt_out",   bus.cnt_out,   e.cnt);
        check("limit_out", bus.limit_out, e.lim);
        check("overflow",  bus.overflow,  e.ovf);
        check("underflow", bus.underflow, e.unf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int  cyc;
    int  pat;
    rst_n             = 1'b0;
    bus.step          = '0;
    bus.down          = 1'b0;
    bus.carry_en      = 1'b0;
    bus.limit_en      = 1'b0;
    bus.limit_capture = 1'b0;
    bus.clear         = 1'b0;
    tick();
    tick();
    check("reset_cnt", bus.cnt_out, 12'h000);
    check("reset_lim", bus.limit_out, 12'h999);
    rst_n = 1'b1;

    // Single-cycle press on digit 0.
    bus.step = 3'b001;
    tick();
    check("t1_cnt", bus.cnt_out, 12'h001);
    check("t1_ovf", bus.overflow, 1'b0);
    bus.step = '0;
    tick();

    // Ripple carry enabled vs disabled from 0x099.
    pulse_clear();
    bus.down = 1'b1;
    press(0); press(1);
    bus.down = 1'b0; bus.carry_en = 1'b1;
    press(0);
    check("t2_carry", bus.cnt_out, 12'h100);
    pulse_clear();
    bus.down = 1'b1; bus.carry_en = 1'b0;
    press(0); press(1);
    bus.down = 1'b0;
    press(0);
    check("t2_nocarry", bus.cnt_out, 12'h090);

    // Top-digit overflow and underflow pulses.
    pulse_clear();
    bus.down = 1'b1;
    press(0); press(1); press(2);
    bus.down = 1'b0; bus.carry_en = 1'b1;
    bus.step = 3'b001;
    tick();
    check("t3_wrap", bus.cnt_out, 12'h000);
    check("t3_ovf_hi", bus.overflow, 1'b1);
    bus.step = '0;
    tick();
    check("t3_ovf_lo", bus.overflow, 1'b0);
    bus.down = 1'b1;
    bus.step = 3'b001;
    tick();
    check("t3_unwrap", bus.cnt_out, 12'h999);
    check("t3_unf_hi", bus.underflow, 1'b1);
    bus.step = '0;
    tick();
    check("t3_unf_lo", bus.underflow, 1'b0);

    // Hold-to-repeat on digit 1, with an ignored press on digit 0.
    pulse_clear();
    bus.down = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.step = (i >= 3 && i < 7) ? 3'b011 : 3'b010;
      tick();
    end
    bus.step = '0;
    tick();
    check("t4_repeat", bus.cnt_out, 12'h040);

    // Captured ceilings.
    pulse_clear();
    bus.carry_en = 1'b0;
    for (int i = 0; i < 3; i++) press(0);
    for (int i = 0; i < 5; i++) press(1);
    for (int i = 0; i < 2; i++) press(2);
    bus.limit_capture = 1'b1;
    tick();
    bus.limit_capture = 1'b0;
    check("t5_lim", bus.limit_out, 12'h253);
    bus.limit_en = 1'b1;
    press(0);
    check("t5_ceil_up", bus.cnt_out, 12'h250);
    bus.down = 1'b1;
    press(0);
    check("t5_ceil_dn", bus.cnt_out, 12'h253);
    bus.down = 1'b0; bus.limit_en = 1'b0;
    press(1); press(1);
    bus.limit_en = 1'b1; bus.down = 1'b1;
    press(1);
    check("t5_clamp", bus.cnt_out, 12'h253);

    // Clear beats a simultaneous press; reset in the middle of a hold.
    bus.limit_en = 1'b0; bus.down = 1'b0;
    bus.step  = 3'b100;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick(); tick(); tick();
    check("t6_clear", bus.cnt_out, 12'h000);
    bus.step = '0;
    tick();
    bus.step = 3'b100;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_cnt", bus.cnt_out, 12'h000);
    check("t6_rst_lim", bus.limit_out, 12'h999);
    rst_n    = 1'b1;
    bus.step = '0;
    tick();

    // Randomised phases of held patterns and mode changes.
    for (int p = 0; p < 70; p++) begin
      bus.down     = 1'($urandom_range(0, 1));
      bus.carry_en = 1'($urandom_range(0, 1));
      bus.limit_en = 1'($urandom_range(0, 1));
      pat          = $urandom_range(0, 7);
      cyc          = $urandom_range(1, 24);
      bus.step     = DIGITS'(pat);
      for (int c = 0; c < cyc; c++) begin
        bus.limit_capture = ($urandom_range(0, 14) == 0);
        bus.clear         = (m_held < 0) && ($urandom_range(0, 19) == 0);
        tick();
      end
      bus.limit_capture = 1'b0;
      bus.clear         = 1'b0;
    end

    bus.step = '0;
    tick();
    tick();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
